// File: rtl/dport_idle_gen.sv
// rtl/dport_idle_gen.sv - DisplayPort main-link idle / TPS1 / TPS2 pattern source with BE injection
// Define DPORT_SCRAMBLE_EN to scramble idle data bytes; otherwise data goes out raw.
module dport_idle_gen #(
  parameter int IDLE_LEN = 4096,
  parameter int SR_EVERY = 512
) (
  input  logic        dpclk,
  input  logic        reset,
  input  logic [1:0]  tp,
  input  logic        trig,
  output logic [15:0] txdat0,
  output logic [15:0] txdat1,
  output logic [1:0]  txisk0,
  output logic [1:0]  txisk1,
  output logic        srpulse
);

  localparam int CW = (IDLE_LEN > 1) ? $clog2(IDLE_LEN) : 1;
  localparam int BW = (SR_EVERY > 1) ? $clog2(SR_EVERY) : 1;

  localparam logic [7:0] SYM_BS    = 8'hBC;
  localparam logic [7:0] SYM_SR    = 8'h1C;
  localparam logic [7:0] SYM_BE    = 8'hFB;
  localparam logic [7:0] SYM_D11_6 = 8'hCB;
  localparam logic [7:0] SYM_D10_2 = 8'h4A;
  localparam logic [7:0] VBID      = 8'h08;

  typedef enum logic [1:0] {
    PAT_IDLE = 2'd0,
    PAT_TPS1 = 2'd1,
    PAT_TPS2 = 2'd2
  } pat_t;

  pat_t          sel_q, cur_q, cur_d;
  logic          restart;
  logic [CW-1:0] c_q, c_d, c_eff;
  logic [BW-1:0] bs_q, bs_d, bs_eff;
  logic [2:0]    t_q, t_d, t_eff;
  logic          pend_q, pend_d;
  logic [15:0]   dat_d;
  logic [1:0]    isk_d;
  logic          be_d, sr_d;
  logic [7:0]    m0, m1;

`ifdef DPORT_SCRAMBLE_EN
  logic [15:0] lfsr_q, lfsr_d, l1, l2;

  // Eight serial steps of the x^16+x^5+x^4+x^3+1 Galois LFSR, LSB of the mask first.
  function automatic logic [23:0] scr8(input logic [15:0] seed);
    logic [15:0] s;
    logic [7:0]  b;
    s = seed;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i] = s[15];
      s = {s[14:0], s[15]} ^ (s[15] ? 16'h0038 : 16'h0000);
    end
    return {s, b};
  endfunction
`endif

  always_comb begin
    restart = (sel_q != cur_q);
    cur_d   = sel_q;
    c_eff   = restart ? '0 : c_q;
    bs_eff  = restart ? '0 : bs_q;
    t_eff   = restart ? 3'd0 : t_q;
    c_d     = c_q;
    bs_d    = bs_q;
    t_d     = t_q;
    pend_d  = pend_q | trig;
    dat_d   = '0;
    isk_d   = '0;
    be_d    = 1'b0;
    sr_d    = (sel_q == PAT_IDLE) && (c_eff == '0) && (bs_eff == '0);
`ifdef DPORT_SCRAMBLE_EN
    lfsr_d  = lfsr_q;
    // SR reseeds before byte 1, so byte 1 then takes the first mask (m0).
    {l1, m0} = scr8((sr_d || restart) ? 16'hFFFF : lfsr_q);
    {l2, m1} = scr8(l1);
`else
    m0 = 8'h00;
    m1 = 8'h00;
`endif
    case (sel_q)
      PAT_TPS1: dat_d = {SYM_D10_2, SYM_D10_2};
      PAT_TPS2: begin
        if (t_eff < 3'd2) begin
          dat_d = {SYM_D11_6, SYM_BS};
          isk_d = 2'b01;
        end else begin
          dat_d = {SYM_D10_2, SYM_D10_2};
        end
        t_d = (t_eff == 3'd4) ? 3'd0 : t_eff + 3'd1;
      end
      default: begin
        if (c_eff == '0) begin
          dat_d = {VBID ^ (sr_d ? m0 : m1), sr_d ? SYM_SR : SYM_BS};
          isk_d = 2'b01;
          bs_d  = (bs_eff == BW'(SR_EVERY - 1)) ? '0 : bs_eff + BW'(1);
        end else begin
          dat_d = {m1, m0};
          if ((c_eff != CW'(1)) && pend_q) begin
            be_d   = 1'b1;
            pend_d = 1'b0;
          end
        end
        c_d = (c_eff == CW'(IDLE_LEN - 1)) ? '0 : c_eff + CW'(1);
`ifdef DPORT_SCRAMBLE_EN
        lfsr_d = sr_d ? l1 : l2;
`endif
      end
    endcase
  end

  always_ff @(posedge dpclk) begin
    if (reset) begin
      sel_q   <= PAT_IDLE;
      cur_q   <= PAT_IDLE;
      c_q     <= '0;
      bs_q    <= '0;
      t_q     <= '0;
      pend_q  <= 1'b0;
      txdat0  <= '0;
      txdat1  <= '0;
      txisk0  <= '0;
      txisk1  <= '0;
      srpulse <= 1'b0;
    end else begin
      sel_q   <= (tp == 2'd1) ? PAT_TPS1 : (tp == 2'd2) ? PAT_TPS2 : PAT_IDLE;
      cur_q   <= cur_d;
      c_q     <= c_d;
      bs_q    <= bs_d;
      t_q     <= t_d;
      pend_q  <= pend_d;
      txdat1  <= dat_d;
      txisk1  <= isk_d;
      txdat0  <= be_d ? {SYM_BE, dat_d[7:0]} : dat_d;
      txisk0  <= be_d ? {1'b1, isk_d[0]} : isk_d;
      srpulse <= sr_d;
    end
  end

`ifdef DPORT_SCRAMBLE_EN
  always_ff @(posedge dpclk) begin
    if (reset) lfsr_q <= 16'hFFFF;
    else       lfsr_q <= lfsr_d;
  end
`endif

endmodule

// File: tb/tb_dport_idle_gen.sv
// tb/tb_dport_idle_gen.sv - self-checking bench for dport_idle_gen against a pattern-level model
module tb_dport_idle_gen;

  localparam int IL = 64;
  localparam int SE = 8;
`ifdef DPORT_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic        dpclk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  tp = 2'd0;
  logic        trig = 1'b0;
  logic [15:0] txdat0, txdat1;
  logic [1:0]  txisk0, txisk1;
  logic        srpulse;

  dport_idle_gen #(.IDLE_LEN(IL), .SR_EVERY(SE)) dut (
    .dpclk(dpclk), .reset(reset), .tp(tp), .trig(trig),
    .txdat0(txdat0), .txdat1(txdat1), .txisk0(txisk0), .txisk1(txisk1),
    .srpulse(srpulse)
  );

  always #5 dpclk = ~dpclk;

  int checks = 0;
  int errors = 0;

  logic [7:0] seq [0:65534];
  int          m_sel, m_last, m_cyc, m_n, last_kk;
  bit          m_pend;
  logic [36:0] exp_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] scr(input int n);
    return SCR ? seq[n % 65535] : 8'h00;
  endfunction

  // Expected outputs for one edge, built from period position / period number.
  task automatic model_edge(input logic rst, input logic [1:0] tpv, input logic trg);
    logic [7:0] b0, b1;
    logic [1:0] k;
    bit be, sr;
    int kk, p;
    if (rst) begin
      exp_v = '0; m_sel = 0; m_last = 0; m_cyc = 0; m_pend = 0; last_kk = -1;
      return;
    end
    if (m_sel != m_last) m_cyc = 0;
    be = 0; sr = 0; k = 2'b00; kk = -1;
    if (m_sel == 1) begin
      b0 = 8'h4A; b1 = 8'h4A;
    end else if (m_sel == 2) begin
      if ((m_cyc % 5) < 2) begin b0 = 8'hBC; b1 = 8'hCB; k = 2'b01; end
      else begin b0 = 8'h4A; b1 = 8'h4A; end
    end else begin
      kk = m_cyc % IL;
      p  = m_cyc / IL;
      if (kk == 0) begin
        sr = ((p % SE) == 0);
        if (sr) begin m_n = 0; b0 = 8'h1C; end
        else begin b0 = 8'hBC; m_n++; end
        b1 = 8'h08 ^ scr(m_n); m_n++;
        k = 2'b01;
      end else begin
        b0 = scr(m_n); m_n++;
        b1 = scr(m_n); m_n++;
        be = (kk >= 2) && m_pend;
      end
    end
    exp_v = {be ? 8'hFB : b1, b0, b1, b0, be ? {1'b1, k[0]} : k, k, sr};
    last_kk = kk;
    m_last = m_sel;
    m_cyc++;
    m_pend = be ? 1'b0 : (m_pend | trg);
    m_sel = (tpv == 2'd1) ? 1 : (tpv == 2'd2) ? 2 : 0;
  endtask

  task automatic step(input logic rst, input logic [1:0] tpv, input logic trg);
    reset = rst; tp = tpv; trig = trg;
    @(posedge dpclk);
    #1;
    model_edge(rst, tpv, trg);
    chk("cycle", {27'd0, txdat0, txdat1, txisk0, txisk1, srpulse}, {27'd0, exp_v});
  endtask

  task automatic run_to_kk(input int target);
    int guard = 0;
    while (last_kk != target && guard < 3 * IL) begin
      step(1'b0, 2'd0, 1'b0);
      guard++;
    end
    checks++;
    assert (last_kk == target) else begin
      errors++;
      $error("FAIL reach_c%0d observed=%0d expected=%0d", target, last_kk, target);
    end
  endtask

  initial begin
    logic [15:0] s;
    logic [7:0]  v;
    bit          fb;
    int          sr_cnt, bs_cnt, be_cnt;
    logic [1:0]  rtp;

    s = 16'hFFFF;
    for (int j = 0; j < 65535; j++) begin
      for (int b = 0; b < 8; b++) begin
        v[b] = s[15];
        fb = s[15];
        s = {s[14:0], fb};
        if (fb) s[5:3] = s[5:3] ^ 3'b111;
      end
      seq[j] = v;
    end
    if (SCR) chk("scr_prefix", {16'd0, seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]},
                 64'h0000_FF17_C014_B2E7);

    m_sel = 0; m_last = 0; m_cyc = 0; m_n = 0; m_pend = 0; last_kk = -1; exp_v = '0;

    repeat (3) step(1'b1, 2'd0, 1'b0);
    chk("reset_state", {27'd0, txdat0, txdat1, txisk0, txisk1, srpulse}, 64'd0);

    step(1'b0, 2'd0, 1'b0);
    chk("first_dat0", txdat0, SCR ? 16'hF71C : 16'h081C);
    chk("first_isk_sr", {txisk0, srpulse}, {2'b01, 1'b1});
    step(1'b0, 2'd0, 1'b0);
    chk("second_dat0", {txisk0, txdat0}, {2'b00, SCR ? 16'hC017 : 16'h0000});

    sr_cnt = 1; bs_cnt = 0;
    repeat ((SE + 1) * IL - 2) begin
      step(1'b0, 2'd0, $urandom_range(0, 30) == 0);
      if (srpulse) sr_cnt++;
      if (last_kk == 0 && txdat0[7:0] == 8'hBC) bs_cnt++;
    end
    chk("sr_count", sr_cnt, 2);
    chk("bs_count", bs_cnt, SE - 1);

    step(1'b0, 2'd2, 1'b0);
    step(1'b0, 2'd2, 1'b0);
    chk("tps2_start", {txisk0, txdat0, txdat1}, {2'b01, 16'hCBBC, 16'hCBBC});
    repeat (10) step(1'b0, 2'd2, 1'b0);
    step(1'b0, 2'd1, 1'b0);
    step(1'b0, 2'd1, 1'b0);
    chk("tps1_start", {txisk0, txdat0}, {2'b00, 16'h4A4A});

    step(1'b0, 2'd1, 1'b1);
    step(1'b0, 2'd1, 1'b0);
    step(1'b0, 2'd1, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    chk("reentry_sr", {srpulse, txisk0, txdat0[7:0]}, {1'b1, 2'b01, 8'h1C});
    step(1'b0, 2'd0, 1'b0);
    chk("no_be_c1", txisk0, 2'b00);
    step(1'b0, 2'd0, 1'b0);
    chk("be_after_tps1", {txisk0, txdat0[15:8], txisk1}, {2'b10, 8'hFB, 2'b00});

    run_to_kk(IL - 1);
    step(1'b0, 2'd0, 1'b1);
    step(1'b0, 2'd0, 1'b1);
    step(1'b0, 2'd0, 1'b0);
    chk("be_at_c2", {txisk0, txdat0[15:8]}, {2'b10, 8'hFB});
    chk("be_lane1", {txisk1, txdat1[7:0]}, {2'b00, txdat0[7:0]});
    be_cnt = 1;
    repeat (IL) begin
      step(1'b0, 2'd0, 1'b0);
      if (txisk0[1] && txdat0[15:8] == 8'hFB) be_cnt++;
    end
    chk("single_be", be_cnt, 1);

    run_to_kk(40);
    step(1'b1, 2'd0, 1'b0);
    chk("midreset_zero", {txdat0, txisk0, srpulse}, 19'd0);
    step(1'b0, 2'd0, 1'b0);
    chk("midreset_sr", {srpulse, txdat0}, {1'b1, SCR ? 16'hF71C : 16'h081C});
    step(1'b0, 2'd0, 1'b0);
    chk("midreset_reseed", txdat0, SCR ? 16'hC017 : 16'h0000);

    rtp = 2'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) rtp = 2'($urandom_range(0, 3));
      step($urandom_range(0, 99) == 0, rtp, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
